rst_seq_multi: RTL

- Parametrised multi-channel reset/clock-gate sequencer for the clock-and-reset infrastructure.
- After reset release it steps each downstream domain through a fixed sequence: clock gate open, reset release, clock gate closed.
- Channels are staggered by a programmable offset so domains come up one after another.
- Adds a reset synchroniser (asynchronous assert, synchronous deassert), a soft-reset restart and status outputs.

---
 rtl/rst_seq_multi.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rst_seq_multi.sv
// Multi-channel reset / clock-gate sequencer.
// Once reset is released, a shared counter steps every channel through
// three phases: gate open, reset release, gate closed. Each channel's
// thresholds are shifted by i*STAGGER so the domains come up in turn.
// A soft request restarts the sequence from count 0.
//
//   state | meaning
//   ------+-------------------------------------------------------
//   RST   | waiting for the synchronised reset deassertion
//   SEQ   | counter running, channel outputs follow the count
//   DONE  | counter saturated at SEQ_END, all channels released
module rst_seq_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int GATE_ON     = 5,
  parameter int RELEASE     = 11,
  parameter int GATE_OFF    = 18,
  parameter int STAGGER     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_rst_req_i,
  output logic [NUM_CH-1:0] release_reset_o,
  output logic [NUM_CH-1:0] gate_clk_o,
  output logic              busy_o,
  output logic              seq_done_o
);

  localparam int SEQ_END = GATE_OFF + (NUM_CH - 1) * STAGGER;

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("rst_seq_multi: NUM_CH must be in 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_seq_multi: SYNC_STAGES must be at least 2");
  end
  if (!(GATE_ON < RELEASE && RELEASE < GATE_OFF)) begin : g_bad_order
    $error("rst_seq_multi: need GATE_ON < RELEASE < GATE_OFF");
  end
  if (GATE_ON < 0 || STAGGER < 0) begin : g_bad_neg
    $error("rst_seq_multi: GATE_ON and STAGGER must be non-negative");
  end
  if (SEQ_END >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("rst_seq_multi: CNT_W too narrow to hold SEQ_END");
  end

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_SEQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The synchroniser is SYNC_STAGES-1 flops feeding the FSM; the FSM's
  // own exit from RST acts as the last stage, so the block leaves RST on
  // the SYNC_STAGES-th edge after reset rises.
  logic [SYNC_STAGES-2:0] sync_q, sync_d;
  logic                   rst_sync_rel;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               soft_clr;

  logic [NUM_CH-1:0]  gate_q, gate_d;
  logic [NUM_CH-1:0]  rel_q, rel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Shift a constant one through the deassertion chain.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = 1'b1;
    for (int i = 1; i < SYNC_STAGES - 1; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rst_sync_rel = sync_q[SYNC_STAGES-2];

  // Synchroniser flops: asynchronous assert, synchronous deassert.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      gate_q  <= '0;
      rel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      rel_q   <= rel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and counter; a soft request beats the DONE transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    soft_clr = 1'b0;
    unique case (state_q)
      ST_RST: begin
        cnt_d = '0;
        if (rst_sync_rel) begin
          state_d = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (soft_rst_req_i) begin
          cnt_d    = '0;
          soft_clr = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(SEQ_END)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (soft_rst_req_i) begin
          state_d  = ST_SEQ;
          cnt_d    = '0;
          soft_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Channel windows decoded from the count being loaded this edge.
  always_comb begin
    gate_d = '0;
    rel_d  = '0;
    busy_d = (state_d == ST_SEQ);
    done_d = (state_d == ST_DONE);
    if (state_d != ST_RST && !soft_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        gate_d[i] = (cnt_d >= CNT_W'(GATE_ON + i * STAGGER)) &&
                    (cnt_d <  CNT_W'(GATE_OFF + i * STAGGER));
        rel_d[i]  = (cnt_d >= CNT_W'(RELEASE + i * STAGGER));
      end
    end
  end

  assign gate_clk_o      = gate_q;
  assign release_reset_o = rel_q;
  assign busy_o          = busy_q;
  assign seq_done_o      = done_q;

endmodule
